tunnel_segment_gen: RTL

Consumer of the 8-bit LFSR random value. Once every SCROLL_DIV frames it samples the random byte and computes the next tunnel row as a random walk of the tunnel centre, clamped to the screen. The last DEPTH rows are kept in a register ring buffer. The pixel/colourizer logic reads the rows back by relative row index.

---
 rtl/tunnel_segment_gen_if.sv | 23 ++
 rtl/tunnel_segment_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/tunnel_segment_gen_if.sv
// Bundle of the frame/random inputs and the row read-back port of tunnel_segment_gen.
interface tunnel_segment_gen_if #(
  parameter int ADDR_W = 4
);
  logic              frame_tick;
  logic              enable;
  logic [7:0]        rand_in;
  logic [ADDR_W-1:0] rd_row;
  logic [7:0]        rd_left;
  logic [7:0]        rd_right;
  logic [ADDR_W-1:0] head;
  logic              busy;

  modport master (
    output frame_tick, enable, rand_in, rd_row,
    input  rd_left, rd_right, head, busy
  );

  modport slave (
    input  frame_tick, enable, rand_in, rd_row,
    output rd_left, rd_right, head, busy
  );
endinterface

// File: rtl/tunnel_segment_gen.sv
// Tunnel row generator: random walk of the tunnel centre, last DEPTH rows kept in a ring buffer.
// Optional macro NARROW_EN: half-width shrinks by one every 16 generated rows down to MIN_HALF_W.
module tunnel_segment_gen #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int SCREEN_W    = 160,
  parameter int INIT_HALF_W = 40,
  parameter int MIN_HALF_W  = 16,
  parameter int MAX_STEP    = 4,
  parameter int SCROLL_DIV  = 4
) (
  input logic               clock,
  input logic               rst,
  tunnel_segment_gen_if.slave bus
);
  localparam int CNT_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [7:0] INIT_C = 8'(SCREEN_W / 2);
  localparam logic [7:0] INIT_L = 8'(SCREEN_W / 2 - INIT_HALF_W);
  localparam logic [7:0] INIT_R = 8'(SCREEN_W / 2 + INIT_HALF_W);
  localparam logic signed [9:0] STEP_S = 10'(MAX_STEP);
  localparam logic signed [9:0] XMAX_S = 10'(SCREEN_W - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, COMPUTE, WRITE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        frame_cnt_q, frame_cnt_d;
  logic [2:0]              rand_q, rand_d;
  logic [7:0]              centre_q, centre_d;
  logic [7:0]              row_l_q, row_l_d, row_r_q, row_r_d;
  logic [ADDR_W-1:0]       head_q, head_d;
  logic [DEPTH-1:0][7:0]   left_q, left_d, right_q, right_d;
  logic [7:0]              rd_left_q, rd_left_d, rd_right_q, rd_right_d;
  logic [ADDR_W-1:0]       rd_addr;
  logic [7:0]              half_w;

`ifdef NARROW_EN
  logic [3:0] row_cnt_q, row_cnt_d;
  logic [7:0] half_w_q, half_w_d;
  assign half_w = half_w_q;
`else
  assign half_w = 8'(INIT_HALF_W);
`endif

  logic signed [9:0] delta, hw_s, c_raw, c_new, l_s, r_s;

  // Random walk step: delta clamped to +-MAX_STEP, centre clamped so both walls stay on screen.
  always_comb begin
    hw_s  = $signed({2'b00, half_w});
    delta = $signed({7'd0, rand_q}) - 10'sd4;
    if (delta > STEP_S)  delta = STEP_S;
    if (delta < -STEP_S) delta = -STEP_S;
    c_raw = $signed({2'b00, centre_q}) + delta;
    c_new = c_raw;
    if (c_new < hw_s)          c_new = hw_s;
    if (c_new > XMAX_S - hw_s) c_new = XMAX_S - hw_s;
    l_s   = c_new - hw_s;
    r_s   = c_new + hw_s;
  end

  assign rd_addr = head_q - ADDR_W'(1) - bus.rd_row;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    rand_d      = rand_q;
    centre_d    = centre_q;
    row_l_d     = row_l_q;
    row_r_d     = row_r_q;
    head_d      = head_q;
    left_d      = left_q;
    right_d     = right_q;
    rd_left_d   = left_q[rd_addr];
    rd_right_d  = right_q[rd_addr];
`ifdef NARROW_EN
    row_cnt_d   = row_cnt_q;
    half_w_d    = half_w_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.enable && bus.frame_tick) begin
          if (frame_cnt_q == CNT_W'(SCROLL_DIV - 1)) begin
            frame_cnt_d = '0;
            state_d     = CAPTURE;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        rand_d  = bus.rand_in[2:0];
        state_d = COMPUTE;
      end
      COMPUTE: begin
        centre_d = c_new[7:0];
        row_l_d  = l_s[7:0];
        row_r_d  = r_s[7:0];
        state_d  = WRITE;
      end
      WRITE: begin
        left_d[head_q]  = row_l_q;
        right_d[head_q] = row_r_q;
        head_d          = head_q + ADDR_W'(1);
`ifdef NARROW_EN
        row_cnt_d = row_cnt_q + 4'd1;
        if (row_cnt_q == 4'hf && half_w_q > 8'(MIN_HALF_W))
          half_w_d = half_w_q - 8'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      frame_cnt_q <= '0;
      rand_q      <= '0;
      centre_q    <= INIT_C;
      row_l_q     <= INIT_L;
      row_r_q     <= INIT_R;
      head_q      <= '0;
      left_q      <= {DEPTH{INIT_L}};
      right_q     <= {DEPTH{INIT_R}};
      rd_left_q   <= '0;
      rd_right_q  <= '0;
`ifdef NARROW_EN
      row_cnt_q   <= '0;
      half_w_q    <= 8'(INIT_HALF_W);
`endif
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      rand_q      <= rand_d;
      centre_q    <= centre_d;
      row_l_q     <= row_l_d;
      row_r_q     <= row_r_d;
      head_q      <= head_d;
      left_q      <= left_d;
      right_q     <= right_d;
      rd_left_q   <= rd_left_d;
      rd_right_q  <= rd_right_d;
`ifdef NARROW_EN
      row_cnt_q   <= row_cnt_d;
      half_w_q    <= half_w_d;
`endif
    end
  end

  assign bus.rd_left  = rd_left_q;
  assign bus.rd_right = rd_right_q;
  assign bus.head     = head_q;
  assign bus.busy     = (state_q != IDLE);
endmodule
